sprite_move_ctrl: RTL
=====================

// Module: sprite_move_ctrl
// PURPOSE
//  Consumes the per-sprite valid-move nibble produced by collision_detect and
//  drives that sprite's tile position back into it, closing the position/valid-move loop.
//  On each game step tick: sample fresh valid moves, choose a direction
//  (buffered request first, then current heading, else stop), update x/y.
//  One instance per sprite: Pac-Man (joystick request) and four ghosts (AI request).
// PARAMETERS
//  START_X    6'd13  reset tile column
//  START_Y    5'd23  reset tile row
//  START_DIR  4'b0100  reset heading (one-hot, LEFT)
//  GRID_W     28     columns; legal x is 0..GRID_W-1
//  TUNNEL_Y   5'd14  row on which horizontal wrap-around is permitted
//  PHASE_SEL  2'd0   clk_100mhz_phase value on which valid_moves is sampled
//  SETTLE     3'd4   min cycles after a position update before valid_moves is trusted
// PORTS
//  clk_100mhz        in   1  system clock; all state on rising edge
//  rst               in   1  asynchronous, active-high reset
//  clk_100mhz_phase  in   2  shared 4-phase time-slot counter
//  enable            in   1  0 = freeze: ticks ignored, position held
//  move_tick         in   1  one-cycle game-step strobe
//  req_dir           in   4  requested direction, one-hot {RIGHT,LEFT,DOWN,UP}
//  valid_moves       in   4  from collision_detect, same bit order as req_dir
//  pos_x             out  6  tile column
//  pos_y             out  5  tile row
//  cur_dir           out  4  current heading, one-hot or 0 (stopped)
//  moved             out  1  one-cycle pulse when pos_x/pos_y change
//  busy              out  1  high while a step is in progress
//  tick_missed       out  1  one-cycle pulse: move_tick arrived while busy
// BEHAVIOUR
//  Reset (async, any state): pos=START_X/START_Y, cur_dir=START_DIR,
//   next_dir=0, settle_cnt=SETTLE, state=IDLE, moved/busy/tick_missed=0.
//  Bit map: [0]=UP(y-1) [1]=DOWN(y+1) [2]=LEFT(x-1) [3]=RIGHT(x+1).
//  req_dir capture, every cycle: exactly one bit set -> next_dir<=req_dir;
//   zero or multi-hot -> next_dir unchanged.
//  settle_cnt: cleared on every position update, increments to SETTLE, saturates.
//  FSM: IDLE --move_tick&enable--> WAIT
//       WAIT --phase==PHASE_SEL & settle_cnt==SETTLE--> sample vm<=valid_moves; DECIDE
//       DECIDE: (next_dir&vm)!=0 -> dir=next_dir, next_dir<=0;
//               else (cur_dir&vm)!=0 -> dir=cur_dir; else dir=0 (stop) -> MOVE
//       MOVE: cur_dir<=dir; if dir!=0 apply step, moved=1; -> IDLE
//  busy=1 in WAIT/DECIDE/MOVE. move_tick while busy -> dropped, tick_missed=1.
//  enable=0 in WAIT/DECIDE: abort to IDLE, no update. enable=0 in MOVE: MOVE completes.
//  Latency: tick at cycle t -> moved at t+3 best case, t+6 worst (settled); fixed
//   2 cycles from sampling to update.
//  Wrap: y==TUNNEL_Y & x==0 & LEFT -> x=GRID_W-1; x==GRID_W-1 & RIGHT -> x=0.
//   Off tunnel row these moves are never valid (map walls); if asserted anyway,
//   x saturates at the boundary (no wrap, moved=0).
//  Arithmetic: unsigned; y is never wrapped; y=0 & UP or y=31 & DOWN -> hold, moved=0.
//  Reversal (e.g. LEFT->RIGHT) allowed whenever valid; no special casing.
// STRUCTURE
//  Shared header game_defs.vh: DIR_UP/DOWN/LEFT/RIGHT one-hot constants,
//   GRID_W, GRID_H, TUNNEL_Y, FSM state encodings.
//  Sub-module dir_select (combinational): {next_dir,cur_dir,vm} -> dir.
//  Top holds FSM, settle counter, next_dir buffer and position registers.
// TESTING
//  1 Reset mid-WAIT -> pos=(13,23), cur_dir=0100, busy=0 on the same edge as rst.
//  2 At (13,23) heading LEFT, vm=1100, tick -> pos_x=12, moved pulses once, cur_dir=0100.
//  3 req_dir=0001 while vm=1100, tick -> keeps LEFT; next tick with vm=0101 -> y=22, UP.
//  4 At (0,14) LEFT, vm=0100, tick -> pos_x=27; at (27,14) RIGHT -> pos_x=0.
//  5 Heading UP, vm=0000, tick -> cur_dir=0000, moved=0, pos unchanged.
//  6 Second tick 1 cycle after first -> tick_missed pulse, single step only;
//    tick 1 cycle after moved -> sample delayed until settle_cnt==4 and phase match.

Source files
------------

// File: rtl/sprite_move_ctrl_pkg.sv
// Shared definitions for the sprite movement controller: direction encodings,
// FSM states and a one-hot test used when buffering joystick/AI requests.
package sprite_move_ctrl_pkg;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  localparam logic [3:0] DIR_STOP  = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_MOVE   = 2'd3
  } move_state_e;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/sprite_move_ctrl_dir_select.sv
// Direction arbitration: buffered request beats current heading; nothing legal means stop.
module sprite_move_ctrl_dir_select
  import sprite_move_ctrl_pkg::*;
(
  input  logic [3:0] next_dir,
  input  logic [3:0] cur_dir,
  input  logic [3:0] vm,
  output logic [3:0] dir,
  output logic       take_next
);

  always_comb begin
    take_next = |(next_dir & vm);
    dir       = DIR_STOP;
    if (take_next)          dir = next_dir;
    else if (|(cur_dir & vm)) dir = cur_dir;
  end

endmodule

// File: rtl/sprite_move_ctrl.sv
// Per-sprite tile mover: on each game tick samples collision_detect's valid moves
// in its phase slot, picks a heading and steps the tile position (tunnel wrap on one row).
module sprite_move_ctrl
  import sprite_move_ctrl_pkg::*;
#(
  parameter logic [5:0] START_X   = 6'd13,
  parameter logic [4:0] START_Y   = 5'd23,
  parameter logic [3:0] START_DIR = 4'b0100,
  parameter int         GRID_W    = 28,
  parameter logic [4:0] TUNNEL_Y  = 5'd14,
  parameter logic [1:0] PHASE_SEL = 2'd0,
  parameter logic [2:0] SETTLE    = 3'd4
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic [1:0] clk_100mhz_phase,
  input  logic       enable,
  input  logic       move_tick,
  input  logic [3:0] req_dir,
  input  logic [3:0] valid_moves,
  output logic [5:0] pos_x,
  output logic [4:0] pos_y,
  output logic [3:0] cur_dir,
  output logic       moved,
  output logic       busy,
  output logic       tick_missed
);

  localparam logic [5:0] X_MAX = 6'(GRID_W - 1);

  move_state_e state;
  logic [3:0]  next_dir, vm, dir_q, sel_dir;
  logic [2:0]  settle_cnt;
  logic        take_next;
  logic [5:0]  step_x;
  logic [4:0]  step_y;
  logic        step_ok;

  sprite_move_ctrl_dir_select u_dir_select (
    .next_dir  (next_dir),
    .cur_dir   (cur_dir),
    .vm        (vm),
    .dir       (sel_dir),
    .take_next (take_next)
  );

  // Candidate position for the decided heading; step_ok=0 means the sprite holds.
  always_comb begin
    step_x  = pos_x;
    step_y  = pos_y;
    step_ok = 1'b0;
    case (dir_q)
      DIR_UP:    if (pos_y != '0) begin step_y = pos_y - 5'd1; step_ok = 1'b1; end
      DIR_DOWN:  if (pos_y != '1) begin step_y = pos_y + 5'd1; step_ok = 1'b1; end
      DIR_LEFT:
        if (pos_x != '0) begin
          step_x = pos_x - 6'd1; step_ok = 1'b1;
        end else if (pos_y == TUNNEL_Y) begin
          step_x = X_MAX; step_ok = 1'b1;
        end
      DIR_RIGHT:
        if (pos_x < X_MAX) begin
          step_x = pos_x + 6'd1; step_ok = 1'b1;
        end else if (pos_y == TUNNEL_Y) begin
          step_x = '0; step_ok = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pos_x       <= START_X;
      pos_y       <= START_Y;
      cur_dir     <= START_DIR;
      next_dir    <= '0;
      vm          <= '0;
      dir_q       <= '0;
      settle_cnt  <= SETTLE;
      moved       <= 1'b0;
      busy        <= 1'b0;
      tick_missed <= 1'b0;
    end else begin
      moved       <= 1'b0;
      tick_missed <= move_tick && (state != ST_IDLE);
      if (settle_cnt < SETTLE) settle_cnt <= settle_cnt + 3'd1;
      case (state)
        ST_IDLE:
          if (move_tick && enable) begin
            state <= ST_WAIT;
            busy  <= 1'b1;
          end
        ST_WAIT:
          if (!enable) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (clk_100mhz_phase == PHASE_SEL && settle_cnt == SETTLE) begin
            vm    <= valid_moves;
            state <= ST_DECIDE;
          end
        ST_DECIDE:
          if (!enable) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            dir_q <= sel_dir;
            if (take_next) next_dir <= '0;
            state <= ST_MOVE;
          end
        ST_MOVE: begin
          cur_dir <= dir_q;
          if (step_ok) begin
            pos_x      <= step_x;
            pos_y      <= step_y;
            moved      <= 1'b1;
            settle_cnt <= '0;
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      // A fresh request in the same cycle outranks consuming the old one.
      if (is_onehot(req_dir)) next_dir <= req_dir;
    end
  end

endmodule
